// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter slice.
//   ARB_N      : number of requesters
//   state_t    : arbiter FSM states
//   grant_t    : one bit per requester
//   onehot_idx : index of the set bit in a one-hot (or zero) vector
package arb_pkg;

  localparam int unsigned ARB_N = 8;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef logic [ARB_N-1:0] grant_t;

  // OR-reduction of bit indices; exact for one-hot inputs, 0 for all-zero.
  function automatic logic [2:0] onehot_idx(input grant_t g);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_N; i++) begin
      if (g[i]) idx |= 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and rr_arbiter8.
//   req     : level-sensitive request lines, bit i = requester i
//   done    : single-cycle release strobe from the current owner
//   grant   : registered one-hot (or zero) grant
//   busy    : high while a grant is held
//   timeout : one-cycle pulse when a grant is forcibly revoked
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  import arb_pkg::*;

  grant_t req;
  logic   done;
  grant_t grant;
  logic   busy;
  logic   timeout;

  modport master (output req, done, input grant, busy, timeout);
  modport slave  (input req, done, output grant, busy, timeout);

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : index with highest priority; scanning proceeds upward, wrapping 7->0
//   pick : one-hot winner (zero when no request)
//   any  : at least one request present
module rr_pick8
  import arb_pkg::*;
(
  input  grant_t     req,
  input  logic [2:0] ptr,
  output grant_t     pick,
  output logic       any
);

  logic [2*ARB_N-1:0] dbl_req;
  logic [2*ARB_N-1:0] dbl_pick;
  grant_t             rot;
  grant_t             first;

  always_comb begin
    // Rotate right so bit ptr lands at position 0.
    dbl_req  = {req, req} >> ptr;
    rot      = dbl_req[ARB_N-1:0];
    // Isolate the lowest set bit.
    first    = rot & (~rot + 1'b1);
    // Rotate back left into original bit positions.
    dbl_pick = {first, first} << ptr;
    pick     = dbl_pick[2*ARB_N-1:ARB_N];
    any      = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with grant hold and timeout.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : rr_arbiter8_if slave port (req, done in; grant, busy, timeout out)
// Parameters:
//   TIMEOUT : maximum cycles a grant may be held (2..255)
//   CNT_W   : hold counter width, 2**CNT_W > TIMEOUT
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
)(
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  state_t             state;
  grant_t             grant_q;
  logic               busy_q;
  logic               timeout_q;
  logic [2:0]         ptr;
  logic [CNT_W-1:0]   cnt;

  grant_t             pick;
  logic               any;
  logic [2:0]         owner;
  logic               owner_req;
  logic               at_limit;
  logic               release_now;

  rr_pick8 u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign owner       = onehot_idx(grant_q);
  assign owner_req   = |(bus.req & grant_q);
  assign at_limit    = (cnt == CNT_W'(TIMEOUT - 1));
  assign release_now = bus.done || !owner_req || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            cnt     <= '0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          cnt <= cnt + 1'b1;
          if (release_now) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr       <= owner + 3'd1;
            state     <= IDLE;
            // A coincident done or request drop makes this a normal release.
            timeout_q <= at_limit && !bus.done && owner_req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter for eight requesters, producing a registered one-hot grant vector. It sits directly upstream of the 8-to-3 one-hot encoder, which converts `grant` to a 3-bit index plus `valid`. Grants are held until the owner releases, the owner drops its request, or a hold timeout expires. Fairness comes from a rotating priority pointer.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles a grant may be held. Legal range is 2..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy 2^`CNT_W` > `TIMEOUT`.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous assert and active-low.
- `req` input 8: request lines; bit i is requester i. Level-sensitive.
- `done` input 1: single-cycle release strobe from the current owner. Ignored while no grant is held.
- `grant` output 8: registered grant, always one-hot or zero. Feeds the encoder input directly.
- `busy` output 1: high while a grant is held. Equals `|grant`, registered.
- `timeout` output 1: single-cycle pulse when a grant is forcibly revoked.

## Operation
States: IDLE and HOLD.

Reset (asynchronous, `rst_n` low), all of the following apply:
- state becomes IDLE;
- `grant` becomes 8'h00;
- `busy` and `timeout` become 0;
- pointer `ptr` becomes 3'd0;
- hold counter becomes 0.

IDLE:
- If `req` is nonzero, pick the first set bit, scanning upward from `ptr` and wrapping 7→0.
- Register the chosen bit into `grant`, clear the counter, and go to HOLD.
- If `req` is zero, stay in IDLE with `grant` at 0.

HOLD:
- The counter increments every cycle.
- Release is triggered by any one of:
  - `done` = 1;
  - `req[owner]` = 0;
  - counter equals `TIMEOUT`-1.
- On release:
  - `grant` is cleared to 0;
  - `ptr` becomes owner+1 mod 8 (7 wraps to 0);
  - state returns to IDLE.
- The timeout cause additionally pulses `timeout` for exactly one cycle, aligned with `grant` going to 0.
- If `done` or a request drop coincides with the timeout cycle, the release counts as normal and `timeout` stays 0.

Other rules:
- Requests other than the owner's are ignored during HOLD. Changes to them do not affect `grant`.
- `ptr` updates only on release, never in IDLE.
- `grant` must never have more than one bit set. This is an assertion target.

## Timing
- Grant latency: a request sampled at edge N in IDLE produces `grant` valid after edge N. It is visible in cycle N+1.
- Release latency: a release condition sampled at edge M clears `grant` after edge M.
- There is one mandatory IDLE cycle between consecutive grants. The next grant appears after edge M+1 at the earliest.
- Maximum hold is `TIMEOUT` cycles of `grant` high.
- `done` and a new `req` in the same cycle: the release happens first. The new request is considered in the following IDLE cycle, using the updated `ptr`.
- Reset asserted mid-HOLD: `grant` drops immediately (asynchronously). After release of reset, arbitration restarts from `ptr` = 0.
- `rst_n` deassertion is assumed synchronised externally. The block does not need to tolerate a metastable release.

## Structure
- Shared package `arb_pkg`:
  - constant `ARB_N` = 8;
  - state enum {IDLE, HOLD};
  - `grant_t` as logic [ARB_N-1:0].
- Sub-module `rr_pick8` (combinational):
  - inputs `req`[7:0] and `ptr`[2:0];
  - outputs one-hot `pick`[7:0] and `any`;
  - implemented as rotate right by `ptr`, find-first-set, then rotate back.
- The top level holds the FSM, the counter, the pointer and the output registers.

## Test plan
- Reset then a single request: `req`=8'h04 → `grant`=8'h04 one cycle later and `busy`=1. A `done` pulse gives `grant`=0 next cycle and `ptr`=3.
- All requesting: `req`=8'hFF, with `done` issued every 2nd HOLD cycle → grants cycle 01,02,04,…,80,01 with an idle cycle between each.
- Wrap-around: owner 7 releases with `req`=8'h81 → the next grant is 8'h01, not 8'h80.
- Timeout: `TIMEOUT`=4, `req`=8'h10 held and no `done` → `grant` high 4 cycles, then 0 with `timeout`=1 for one cycle. The next grant is 8'h10 again, after one idle cycle.
- Request drop: owner 2 deasserts `req[2]` mid-HOLD → `grant`=0 next cycle, `timeout`=0, `ptr`=3.
- Asynchronous reset mid-HOLD: `rst_n` low between edges → `grant`, `busy` and `timeout` go to 0 immediately. After reset is released with `req`=8'hFF, the first grant is 8'h01.
